// File: rtl/seq_divider_32bit.sv
// Iterative restoring divider: one trial subtraction per cycle, signed/unsigned,
// with divide-by-zero and signed-overflow results resolved at accept time.
module seq_divider_32bit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             In_valid,
  output logic             In_ready,
  input  logic             Is_signed,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             Out_valid,
  input  logic             Out_ready,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Div_zero
);

  // state | meaning
  // IDLE  | waiting for an operation
  // CALC  | one shift/trial-subtract per cycle, WIDTH cycles
  // FIX   | apply result signs
  // DONE  | result held until Out_ready
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             dz_q, dz_d;

  logic             a_neg, b_neg, ovf_case, carry;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   r_shift, trial;

  assign a_neg    = Is_signed & Dividend[WIDTH-1];
  assign b_neg    = Is_signed & Divisor[WIDTH-1];
  assign a_mag    = a_neg ? (~Dividend + 1'b1) : Dividend;
  assign b_mag    = b_neg ? (~Divisor + 1'b1) : Divisor;
  assign ovf_case = Is_signed && (Dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (Divisor == '1);

  // R' < 2*Div always holds, so bit WIDTH of the trial is exactly the inverted carry-out.
  assign r_shift = {rem_q, dvd_q[WIDTH-1]};
  assign trial   = r_shift + {1'b1, ~div_q} + 1'b1;
  assign carry   = ~trial[WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    div_d   = div_q;
    rem_d   = rem_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    quo_d   = quo_q;
    remo_d  = remo_q;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE: begin
        if (In_valid) begin
          if (Divisor == '0) begin
            quo_d   = '1;
            remo_d  = Dividend;
            dz_d    = 1'b1;
            state_d = DONE;
          end else if (ovf_case) begin
            quo_d   = {1'b1, {(WIDTH-1){1'b0}}};
            remo_d  = '0;
            dz_d    = 1'b0;
            state_d = DONE;
          end else begin
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
            dvd_d   = a_mag;
            div_d   = b_mag;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = carry ? trial[WIDTH-1:0] : r_shift[WIDTH-1:0];
        dvd_d = {dvd_q[WIDTH-2:0], carry};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) state_d = FIX;
      end
      FIX: begin
        quo_d   = qneg_q ? (~dvd_q + 1'b1) : dvd_q;
        remo_d  = rneg_q ? (~rem_q + 1'b1) : rem_q;
        dz_d    = 1'b0;
        state_d = DONE;
      end
      DONE: begin
        if (Out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      div_q   <= '0;
      rem_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      quo_q   <= '0;
      remo_q  <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      quo_q   <= quo_d;
      remo_q  <= remo_d;
      dz_q    <= dz_d;
    end
  end

  assign In_ready  = (state_q == IDLE);
  assign Out_valid = (state_q == DONE);
  assign Quotient  = quo_q;
  assign Remainder = remo_q;
  assign Div_zero  = dz_q;

endmodule
